// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load extension encodings, write-back entry layout.
package mips_pkg;

  // Default number of write-back buffer entries
  localparam int unsigned DefaultDepth = 2;

  // Load extension type as carried on in_loadType
  typedef enum logic [1:0] {
    LdWord  = 2'd0,
    LdByteS = 2'd1,
    LdByteU = 2'd2,
    LdHalfS = 2'd3
  } load_type_e;

  // One buffered register-file write
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // An entry only touches the register file if enabled and not aimed at $zero
  function automatic logic entry_writes(input wb_entry_t e);
    return e.reg_write && (e.addr != 5'd0);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the addressed byte/half of a memory
// word and sign- or zero-extends it to 32 bits.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] read_data_i,
  input  logic [1:0]  load_type_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] ext_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection: byte 0 is bits 7:0, half select uses offset bit 1
  always_comb begin
    byte_sel = read_data_i[{byte_off_i, 3'b000} +: 8];
    half_sel = byte_off_i[1] ? read_data_i[31:16] : read_data_i[15:0];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    ext_data_o = read_data_i;
    case (load_type_e'(load_type_i))
      LdWord:  ext_data_o = read_data_i;
      LdByteS: ext_data_o = {{24{byte_sel[7]}}, byte_sel};
      LdByteU: ext_data_o = {24'd0, byte_sel};
      LdHalfS: ext_data_o = {{16{half_sel[15]}}, half_sel};
      default: ext_data_o = read_data_i;
    endcase
  end

endmodule

// File: rtl/wb_write_unit.sv
// Write-back unit: buffers MEM-stage results in a small FIFO, arbitrates the single
// register-file write port between debug writes and the FIFO head, and forwards
// pending buffered writes to the decode stage.
module wb_write_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_memToReg,
  input  logic        in_regWrite,
  input  logic [4:0]  in_writeReg,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_readData,
  input  logic [1:0]  in_loadType,
  input  logic [1:0]  in_byteOff,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        regWrite,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData,
  input  logic [4:0]  qAddr1,
  input  logic [4:0]  qAddr2,
  output logic        fwdHit1,
  output logic        fwdHit2,
  output logic [31:0] fwdData1,
  output logic [31:0] fwdData2,
  output logic [31:0] retiredCnt
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            out_of_reset_q;
  logic [31:0]     retired_q;

  logic [31:0]     ext_data;
  wb_entry_t       in_entry;
  wb_entry_t       head;
  logic            head_valid;
  logic            push;
  logic            pop;

  int unsigned     fwd_idx;
  wb_entry_t       fwd_entry;

  // Pointer increment that wraps for any DEPTH, not just powers of two
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  load_extend u_load_extend (
    .read_data_i (in_readData),
    .load_type_i (in_loadType),
    .byte_off_i  (in_byteOff),
    .ext_data_o  (ext_data)
  );

  // Result is chosen at accept time so later stages never see raw load data
  always_comb begin
    in_entry.reg_write = in_regWrite;
    in_entry.addr      = in_writeReg;
    in_entry.data      = in_memToReg ? ext_data : in_aluResult;
  end

  // Ready only once an edge has seen rst_n high, and never while full
  always_comb begin
    in_ready   = out_of_reset_q && (count_q < DepthCnt);
    push       = in_valid && in_ready;
    head       = mem_q[rd_ptr_q];
    // Entries pending during reset are being discarded, so hide them immediately
    head_valid = rst_n && (count_q != '0);
    retiredCnt = retired_q;
  end

  // Write-port arbitration: debug first, then FIFO head, else idle
  always_comb begin
    regWrite = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
    pop      = 1'b0;
    if (dbg_we) begin
      regWrite = (dbg_addr != 5'd0);
      wrAddr   = dbg_addr;
      wrData   = dbg_data;
    end else if (head_valid) begin
      regWrite = entry_writes(head);
      wrAddr   = head.addr;
      wrData   = head.data;
      pop      = 1'b1;
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match wins
  always_comb begin
    fwdHit1   = 1'b0;
    fwdData1  = '0;
    fwdHit2   = 1'b0;
    fwdData2  = '0;
    fwd_idx   = 0;
    fwd_entry = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = 32'(rd_ptr_q) + i;
      if (fwd_idx >= DEPTH) begin
        fwd_idx = fwd_idx - DEPTH;
      end
      fwd_entry = mem_q[fwd_idx[PtrW-1:0]];
      if (rst_n && (i < 32'(count_q)) && entry_writes(fwd_entry)) begin
        if (fwd_entry.addr == qAddr1) begin
          fwdHit1  = 1'b1;
          fwdData1 = fwd_entry.data;
        end
        if (fwd_entry.addr == qAddr2) begin
          fwdHit2  = 1'b1;
          fwdData2 = fwd_entry.data;
        end
      end
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed here
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // FIFO control, ready qualifier and retire counter with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      retired_q      <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      out_of_reset_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        retired_q <= retired_q + 32'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_unit.sv
// Self-checking bench for wb_write_unit: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_wb_write_unit;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_memToReg, in_regWrite;
  logic [4:0]  in_writeReg;
  logic [31:0] in_aluResult, in_readData;
  logic [1:0]  in_loadType, in_byteOff;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        regWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  qAddr1, qAddr2;
  logic        fwdHit1, fwdHit2;
  logic [31:0] fwdData1, fwdData2;
  logic [31:0] retiredCnt;

  // Reference model state
  ent_t        q[$];
  logic [31:0] retired_m;
  bit          ready_m;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  wb_write_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_memToReg (in_memToReg),
    .in_regWrite (in_regWrite),
    .in_writeReg (in_writeReg),
    .in_aluResult(in_aluResult),
    .in_readData (in_readData),
    .in_loadType (in_loadType),
    .in_byteOff  (in_byteOff),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .regWrite    (regWrite),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .qAddr1      (qAddr1),
    .qAddr2      (qAddr2),
    .fwdHit1     (fwdHit1),
    .fwdHit2     (fwdHit2),
    .fwdData1    (fwdData1),
    .fwdData2    (fwdData2),
    .retiredCnt  (retiredCnt)
  );

  // Load extension computed arithmetically from the word, type and offset
  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [1:0] lt,
                                          input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * off[1])) & 32'hFFFF;
    case (lt)
      2'd0:    return rd;
      2'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      2'd2:    return b;
      default: return h[15] ? (h | 32'hFFFF_0000) : h;
    endcase
  endfunction

  function automatic bit exp_ready();
    return ready_m && (q.size() < int'(DEPTH));
  endfunction

  function automatic void exp_port(output logic rw, output logic [4:0] a, output logic [31:0] d);
    rw = 1'b0;
    a  = '0;
    d  = '0;
    if (dbg_we) begin
      rw = (dbg_addr != 0);
      a  = dbg_addr;
      d  = dbg_data;
    end else if (rst_n && q.size() > 0) begin
      rw = q[0].rw && (q[0].addr != 0);
      a  = q[0].addr;
      d  = q[0].data;
    end
  endfunction

  function automatic void exp_fwd(input logic [4:0] qa, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rst_n) begin
      foreach (q[i]) begin
        if (q[i].rw && q[i].addr == qa && qa != 0) begin
          hit = 1'b1;
          d   = q[i].data;
        end
      end
    end
  endfunction

  // Advance one clock: decide model actions from pre-edge inputs, apply at the edge
  task automatic tick();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    do_pop  = rst_n && !dbg_we && (q.size() > 0);
    do_push = in_valid && exp_ready();
    e.rw    = in_regWrite;
    e.addr  = in_writeReg;
    e.data  = in_memToReg ? ref_ext(in_readData, in_loadType, in_byteOff) : in_aluResult;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      retired_m = 0;
      ready_m   = 0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        retired_m = retired_m + 1;
      end
      if (do_push) q.push_back(e);
      ready_m = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 0;
    in_memToReg  = 0;
    in_regWrite  = 0;
    in_writeReg  = 0;
    in_aluResult = 0;
    in_readData  = 0;
    in_loadType  = 0;
    in_byteOff   = 0;
    dbg_we       = 0;
    dbg_addr     = 0;
    dbg_data     = 0;
    qAddr1       = 0;
    qAddr2       = 0;
  endtask

  task automatic set_push(input logic rw, input logic [4:0] a, input logic [31:0] d);
    in_valid     = 1;
    in_memToReg  = 0;
    in_regWrite  = rw;
    in_writeReg  = a;
    in_aluResult = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", regWrite); end
    checks++; if (retiredCnt !== 32'd0) begin errors++; $display("FAIL reset_retired: got %h want 0", retiredCnt); end
    checks++; if (fwdHit1 !== 1'b0 || fwdHit2 !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b%b want 00", fwdHit1, fwdHit2); end
    dbg_we = 1; dbg_addr = 5'd3; dbg_data = 32'hDEAD_BEEF;
    #1;
    checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL reset_dbg_port: got %b %h %h want 1 03 deadbeef", regWrite, wrAddr, wrData);
    end
    tick();
    dbg_we = 0;
    rst_n  = 1;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", in_ready); end
    tick();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu_push();
    idle_inputs();
    set_push(1, 5'd5, 32'h1234_5678);
    tick();
    in_valid = 0;
    #2;
    checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      errors++; $display("FAIL alu_port: got %b %h %h want 1 05 12345678", regWrite, wrAddr, wrData);
    end
    tick();
    #2;
    checks++; if (retiredCnt !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d want 1", retiredCnt); end
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL alu_idle: got %b want 0", regWrite); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  lts  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0]  offs [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01};
    logic [31:0] want;
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      in_valid     = 1;
      in_memToReg  = 1;
      in_regWrite  = 1;
      in_writeReg  = 5'd9;
      in_aluResult = $urandom;
      if (i < 4) begin
        in_readData = 32'h80FF_7F01;
        in_loadType = lts[i];
        in_byteOff  = offs[i];
        want        = exps[i];
      end else begin
        in_readData = $urandom;
        in_loadType = 2'($urandom_range(3));
        in_byteOff  = 2'($urandom_range(3));
        want        = ref_ext(in_readData, in_loadType, in_byteOff);
      end
      tick();
      in_valid = 0;
      #2;
      checks++; if (wrData !== want || regWrite !== 1'b1) begin
        errors++; $display("FAIL load_ext[%0d]: got %b %h want 1 %h", i, regWrite, wrData, want);
      end
      tick();
    end
  endtask

  task automatic test_dbg_stall();
    logic [4:0]  ea [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] ed [3] = '{32'h111, 32'h222, 32'h333};
    logic [31:0] base;
    idle_inputs();
    base = retired_m;
    dbg_we = 1;
    for (int c = 0; c < 3; c++) begin
      dbg_addr = 5'(20 + c);
      dbg_data = 32'hD0 + c;
      set_push(1, ea[c], ed[c]);
      #2;
      checks++; if (in_ready !== (c < 2)) begin errors++; $display("FAIL stall_ready[%0d]: got %b want %b", c, in_ready, c < 2); end
      checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, dbg_addr, dbg_data}) begin
        errors++; $display("FAIL stall_dbg_port[%0d]: got %b %h %h want 1 %h %h", c, regWrite, wrAddr, wrData, dbg_addr, dbg_data);
      end
      tick();
    end
    dbg_we = 0;
    #2;
    checks++; if (wrAddr !== 5'd1 || wrData !== 32'h111 || in_ready !== 1'b0) begin
      errors++; $display("FAIL drain0: got %h %h rdy %b want 01 111 rdy 0", wrAddr, wrData, in_ready);
    end
    tick();
    #2;
    checks++; if (wrAddr !== 5'd2 || wrData !== 32'h222 || in_ready !== 1'b1) begin
      errors++; $display("FAIL drain1: got %h %h rdy %b want 02 222 rdy 1", wrAddr, wrData, in_ready);
    end
    tick();
    in_valid = 0;
    #2;
    checks++; if (wrAddr !== 5'd3 || wrData !== 32'h333) begin
      errors++; $display("FAIL drain2: got %h %h want 03 333", wrAddr, wrData);
    end
    tick();
    #2;
    checks++; if (regWrite !== 1'b0 || retiredCnt !== base + 3) begin
      errors++; $display("FAIL drain_done: got %b %0d want 0 %0d", regWrite, retiredCnt, base + 3);
    end
  endtask

  task automatic test_forward();
    idle_inputs();
    dbg_we = 1;
    set_push(1, 5'd7, 32'hA);
    tick();
    set_push(1, 5'd7, 32'hB);
    tick();
    // Unbuffered sources must not forward: in_* and dbg both aim at reg 4
    set_push(1, 5'd4, 32'hC);
    dbg_addr = 5'd4;
    dbg_data = 32'hE;
    qAddr1 = 5'd7;
    qAddr2 = 5'd0;
    #2;
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'hB) begin
      errors++; $display("FAIL fwd_young: got %b %h want 1 0000000b", fwdHit1, fwdData1);
    end
    checks++; if (fwdHit2 !== 1'b0 || fwdData2 !== 32'h0) begin
      errors++; $display("FAIL fwd_r0: got %b %h want 0 0", fwdHit2, fwdData2);
    end
    qAddr2 = 5'd4;
    #1;
    checks++; if (fwdHit2 !== 1'b0 || fwdData2 !== 32'h0) begin
      errors++; $display("FAIL fwd_ignore_inputs: got %b %h want 0 0", fwdHit2, fwdData2);
    end
    in_valid = 0;
    dbg_we   = 0;
    tick();
    #2;
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'hB) begin
      errors++; $display("FAIL fwd_after_pop: got %b %h want 1 0000000b", fwdHit1, fwdData1);
    end
    tick();
    #2;
    checks++; if (fwdHit1 !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %b want 0", fwdHit1); end
  endtask

  task automatic test_reg0();
    logic [31:0] base;
    idle_inputs();
    set_push(1, 5'd0, 32'h55);
    tick();
    set_push(0, 5'd6, 32'h66);
    base = retired_m;
    #2;
    checks++; if (regWrite !== 1'b0 || wrAddr !== 5'd0) begin
      errors++; $display("FAIL reg0_port: got %b %h want 0 00", regWrite, wrAddr);
    end
    tick();
    in_valid = 0;
    #2;
    checks++; if (retiredCnt !== base + 1) begin errors++; $display("FAIL reg0_retired: got %0d want %0d", retiredCnt, base + 1); end
    checks++; if (regWrite !== 1'b0 || wrAddr !== 5'd6) begin
      errors++; $display("FAIL nowrite_port: got %b %h want 0 06", regWrite, wrAddr);
    end
    tick();
    #2;
    checks++; if (retiredCnt !== base + 2) begin errors++; $display("FAIL nowrite_retired: got %0d want %0d", retiredCnt, base + 2); end
  endtask

  task automatic test_reset_stall();
    idle_inputs();
    dbg_we = 1;
    set_push(1, 5'd8, 32'h8);
    tick();
    set_push(1, 5'd9, 32'h9);
    tick();
    in_valid = 0;
    rst_n    = 0;
    tick();
    dbg_we = 0;
    qAddr1 = 5'd8;
    #2;
    checks++; if (retiredCnt !== 32'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rststall_state: got %0d rdy %b want 0 rdy 0", retiredCnt, in_ready);
    end
    checks++; if (regWrite !== 1'b0 || fwdHit1 !== 1'b0) begin
      errors++; $display("FAIL rststall_port: got %b fwd %b want 0 0", regWrite, fwdHit1);
    end
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      checks++; if (regWrite !== 1'b0 || retiredCnt !== 32'd0) begin
        errors++; $display("FAIL rststall_after[%0d]: got %b %0d want 0 0", c, regWrite, retiredCnt);
      end
    end
  endtask

  task automatic test_random();
    logic        e_rw, e_h1, e_h2;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_d1, e_d2;
    for (int c = 0; c < 800; c++) begin
      rst_n        = ($urandom_range(60) != 0);
      in_valid     = ($urandom_range(9) < 6);
      in_memToReg  = 1'($urandom_range(1));
      in_regWrite  = ($urandom_range(7) != 0);
      in_writeReg  = 5'($urandom_range(7));
      in_aluResult = $urandom;
      in_readData  = $urandom;
      in_loadType  = 2'($urandom_range(3));
      in_byteOff   = 2'($urandom_range(3));
      dbg_we       = ($urandom_range(3) == 0);
      dbg_addr     = 5'($urandom_range(31));
      dbg_data     = $urandom;
      qAddr1       = 5'($urandom_range(7));
      qAddr2       = 5'($urandom_range(7));
      #2;
      exp_port(e_rw, e_a, e_d);
      exp_fwd(qAddr1, e_h1, e_d1);
      exp_fwd(qAddr2, e_h2, e_d2);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
      checks++; if (regWrite !== e_rw) begin errors++; $display("FAIL rnd_regwrite c%0d: got %b want %b", c, regWrite, e_rw); end
      checks++; if (wrAddr !== e_a) begin errors++; $display("FAIL rnd_wraddr c%0d: got %h want %h", c, wrAddr, e_a); end
      checks++; if (wrData !== e_d) begin errors++; $display("FAIL rnd_wrdata c%0d: got %h want %h", c, wrData, e_d); end
      checks++; if (fwdHit1 !== e_h1 || fwdData1 !== e_d1) begin
        errors++; $display("FAIL rnd_fwd1 c%0d: got %b %h want %b %h", c, fwdHit1, fwdData1, e_h1, e_d1);
      end
      checks++; if (fwdHit2 !== e_h2 || fwdData2 !== e_d2) begin
        errors++; $display("FAIL rnd_fwd2 c%0d: got %b %h want %b %h", c, fwdHit2, fwdData2, e_h2, e_d2);
      end
      checks++; if (retiredCnt !== retired_m) begin errors++; $display("FAIL rnd_retired c%0d: got %0d want %0d", c, retiredCnt, retired_m); end
      tick();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    retired_m = 0;
    ready_m   = 0;
    rst_n     = 0;
    idle_inputs();
    test_reset();
    test_alu_push();
    test_load_ext();
    test_dbg_stall();
    test_forward();
    test_reg0();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
